snake_cell_map: RTL and testbench

Game-state engine and pixel-query responder for the Snake display path. It holds the snake's segment coordinates on the 40×30 grid of 16×16-pixel cells, and advances the snake one cell per `move_tick`. It handles direction changes, growth on the apple, and wall/self collision. For every `(x_pos, y_pos)` issued by the VGA controller it answers with the 2-bit cell class on `snake`, which the controller uses to pick the pixel colour.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/snake_cell_lookup.sv | 50 +++++
 rtl/snake_cell_map.sv | 113 +++++++++++
 tb/tb_snake_cell_map.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell-class, direction and grid definitions for the snake display path
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_NONE = 2'b00,
    CELL_HEAD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_WALL = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;
  localparam int SEG_W      = 11;
  localparam int HEAD_X0    = 20;
  localparam int HEAD_Y0    = 15;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } seg_t;

  // Opposite directions differ only in bit 0 (up/down, left/right).
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_cell_lookup.sv
// rtl/snake_cell_lookup.sv - pixel-to-cell classification against the live segments
module snake_cell_lookup #(
  parameter int MAX_LEN = 16,
  parameter int GRID_W  = snake_pkg::GRID_W,
  parameter int GRID_H  = snake_pkg::GRID_H
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [9:0]                     x_pos,
  input  logic [9:0]                     y_pos,
  input  logic [MAX_LEN*snake_pkg::SEG_W-1:0] seg_flat,
  input  logic [4:0]                     len,
  output logic [1:0]                     snake
);
  import snake_pkg::*;

  logic [5:0] cx;
  logic [4:0] cy;
  logic       blank;
  logic       head_m;
  logic       body_m;
  logic       wall_m;
  logic [1:0] cls;

  // Classify the queried cell; head beats body beats wall.
  always_comb begin
    cx     = x_pos[9:CELL_SHIFT];
    cy     = y_pos[8:CELL_SHIFT];
    blank  = (x_pos >= 10'd640) || (y_pos >= 10'd480);
    head_m = (seg_flat[SEG_W-1:0] == {cx, cy});
    body_m = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len)) && (seg_flat[i*SEG_W +: SEG_W] == {cx, cy})) body_m = 1'b1;
    end
    wall_m = (cx == 6'd0) || (cx == 6'(GRID_W - 1)) ||
             (cy == 5'd0) || (cy == 5'(GRID_H - 1));
    if (blank)       cls = CELL_NONE;
    else if (head_m) cls = CELL_HEAD;
    else if (body_m) cls = CELL_BODY;
    else if (wall_m) cls = CELL_WALL;
    else             cls = CELL_NONE;
  end

  // Register the class so the answer lands exactly one cycle after the query.
  always_ff @(posedge clk) begin
    if (rst) snake <= CELL_NONE;
    else     snake <= cls;
  end

endmodule

// File: rtl/snake_cell_map.sv
// rtl/snake_cell_map.sv - snake game-state engine with per-pixel cell-class responder
module snake_cell_map #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = snake_pkg::GRID_W,
  parameter int GRID_H   = snake_pkg::GRID_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       dir_valid,
  input  logic [1:0] dir_in,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [5:0] apple_x,
  input  logic [4:0] apple_y,
  output logic [1:0] snake,
  output logic       apple_eaten,
  output logic       hit,
  output logic [4:0] length
);
  import snake_pkg::*;

  seg_t       seg [MAX_LEN];
  logic [4:0] len;
  logic [1:0] dir;
  logic [1:0] dir_pend;

  logic       req_ok;
  logic [1:0] d;
  seg_t       nh;
  logic       grow;
  logic       wall_hit;
  logic       self_hit;
  logic       do_move;
  logic [MAX_LEN*SEG_W-1:0] seg_flat;

  // Next-head candidate and its collision/growth classification.
  always_comb begin
    req_ok = dir_valid && !is_reverse(dir_in, dir);
    d      = req_ok ? dir_in : dir_pend;
    nh     = seg[0];
    case (d)
      DIR_UP:    nh.y = seg[0].y - 5'd1;
      DIR_DOWN:  nh.y = seg[0].y + 5'd1;
      DIR_LEFT:  nh.x = seg[0].x - 6'd1;
      default:   nh.x = seg[0].x + 6'd1;
    endcase
    grow     = (nh.x == apple_x) && (nh.y == apple_y);
    wall_hit = (nh.x == 6'd0) || (nh.x == 6'(GRID_W - 1)) ||
               (nh.y == 5'd0) || (nh.y == 5'(GRID_H - 1));
    // The tail vacates on a plain move, so it only blocks when growing.
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((i + 1 < int'(len)) || (grow && (i < int'(len)))) && (seg[i] == nh)) self_hit = 1'b1;
    end
    do_move = move_tick && !hit;
  end

  // Game state: direction latch, segment shift register, length and collision flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg[i] <= '{x: 6'(HEAD_X0 - i), y: 5'(HEAD_Y0)};
      end
      len         <= 5'(INIT_LEN);
      dir         <= DIR_RIGHT;
      dir_pend    <= DIR_RIGHT;
      hit         <= 1'b0;
      apple_eaten <= 1'b0;
    end else begin
      apple_eaten <= 1'b0;
      if (req_ok) dir_pend <= dir_in;
      if (do_move) begin
        if (wall_hit || self_hit) begin
          hit <= 1'b1;
        end else begin
          seg[0] <= nh;
          for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
          dir      <= d;
          dir_pend <= d;
          if (grow) begin
            apple_eaten <= 1'b1;
            if (len < 5'(MAX_LEN)) len <= len + 5'd1;
          end
        end
      end
    end
  end

  // Flatten the segment array for the lookup port.
  always_comb begin
    seg_flat = '0;
    for (int i = 0; i < MAX_LEN; i++) seg_flat[i*SEG_W +: SEG_W] = seg[i];
  end

  assign length = len;

  snake_cell_lookup #(
    .MAX_LEN (MAX_LEN),
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H)
  ) u_lookup (
    .clk      (clk),
    .rst      (rst),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .seg_flat (seg_flat),
    .len      (len),
    .snake    (snake)
  );

endmodule

// File: tb/tb_snake_cell_map.sv
// tb/tb_snake_cell_map.sv - directed self-checking bench for snake_cell_map
module tb_snake_cell_map;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_tick = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic [9:0] x_pos = 10'd0;
  logic [9:0] y_pos = 10'd0;
  logic [5:0] apple_x = 6'd1;
  logic [4:0] apple_y = 5'd1;
  logic [1:0] snake;
  logic       apple_eaten;
  logic       hit;
  logic [4:0] length;

  int checks = 0;
  int failures = 0;
  logic [1:0] r;
  logic       ate;

  localparam logic [1:0] C_NONE = 2'b00, C_HEAD = 2'b01, C_BODY = 2'b10, C_WALL = 2'b11;

  snake_cell_map dut (
    .clk         (clk),
    .rst         (rst),
    .move_tick   (move_tick),
    .dir_valid   (dir_valid),
    .dir_in      (dir_in),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .snake       (snake),
    .apple_eaten (apple_eaten),
    .hit         (hit),
    .length      (length)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic query(input int x, input int y, output logic [1:0] res);
    @(negedge clk);
    x_pos = 10'(x);
    y_pos = 10'(y);
    @(negedge clk);
    res = snake;
  endtask

  task automatic step(output logic eaten);
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    eaten = apple_eaten;
  endtask

  task automatic send_dir(input logic [1:0] dd);
    @(negedge clk);
    dir_valid = 1'b1;
    dir_in = dd;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic test_reset();
    apple_x = 6'd1; apple_y = 5'd1;
    do_reset();
    checks++; if (length !== 5'd3) begin failures++; $display("FAIL reset_length got=%0d exp=3", length); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0d exp=0", hit); end
    checks++; if (apple_eaten !== 1'b0) begin failures++; $display("FAIL reset_eaten got=%0d exp=0", apple_eaten); end
    query(328, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL reset_head got=%0d exp=%0d", r, C_HEAD); end
    query(312, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL reset_body got=%0d exp=%0d", r, C_BODY); end
    query(296, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL reset_tail got=%0d exp=%0d", r, C_BODY); end
    query(280, 245, r);
    checks++; if (r !== C_NONE) begin failures++; $display("FAIL reset_past_tail got=%0d exp=%0d", r, C_NONE); end
    query(5, 5, r);
    checks++; if (r !== C_WALL) begin failures++; $display("FAIL reset_wall got=%0d exp=%0d", r, C_WALL); end
    query(700, 100, r);
    checks++; if (r !== C_NONE) begin failures++; $display("FAIL reset_blank got=%0d exp=%0d", r, C_NONE); end
    query(100, 480, r);
    checks++; if (r !== C_NONE) begin failures++; $display("FAIL reset_vblank got=%0d exp=%0d", r, C_NONE); end
    query(632, 245, r);
    checks++; if (r !== C_WALL) begin failures++; $display("FAIL reset_right_wall got=%0d exp=%0d", r, C_WALL); end
  endtask

  task automatic test_straight();
    step(ate);
    checks++; if (ate !== 1'b0) begin failures++; $display("FAIL straight_eaten got=%0d exp=0", ate); end
    checks++; if (length !== 5'd3) begin failures++; $display("FAIL straight_length got=%0d exp=3", length); end
    query(336, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL straight_head got=%0d exp=%0d", r, C_HEAD); end
    query(296, 245, r);
    checks++; if (r !== C_NONE) begin failures++; $display("FAIL straight_old_tail got=%0d exp=%0d", r, C_NONE); end
  endtask

  task automatic test_reversal();
    do_reset();
    send_dir(2'b10);
    step(ate);
    query(336, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL rev_head got=%0d exp=%0d", r, C_HEAD); end
    query(320, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL rev_neck got=%0d exp=%0d", r, C_BODY); end
    send_dir(2'b00);
    step(ate);
    query(336, 224, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL up_head got=%0d exp=%0d", r, C_HEAD); end
    query(336, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL up_neck got=%0d exp=%0d", r, C_BODY); end
  endtask

  task automatic test_same_cycle_dir();
    do_reset();
    @(negedge clk);
    dir_valid = 1'b1; dir_in = 2'b01; move_tick = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0; move_tick = 1'b0;
    query(320, 256, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL same_cycle_head got=%0d exp=%0d", r, C_HEAD); end
  endtask

  task automatic test_eat();
    do_reset();
    apple_x = 6'd21; apple_y = 5'd15;
    step(ate);
    checks++; if (ate !== 1'b1) begin failures++; $display("FAIL eat_pulse got=%0d exp=1", ate); end
    apple_x = 6'd1; apple_y = 5'd1;
    @(negedge clk);
    checks++; if (apple_eaten !== 1'b0) begin failures++; $display("FAIL eat_one_cycle got=%0d exp=0", apple_eaten); end
    checks++; if (length !== 5'd4) begin failures++; $display("FAIL eat_length got=%0d exp=4", length); end
    query(288, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL eat_tail got=%0d exp=%0d", r, C_BODY); end
  endtask

  task automatic test_wall();
    do_reset();
    for (int k = 0; k < 18; k++) step(ate);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL wall_pre_hit got=%0d exp=0", hit); end
    step(ate);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL wall_hit got=%0d exp=1", hit); end
    query(608, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL wall_head_stays got=%0d exp=%0d", r, C_HEAD); end
    step(ate);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL wall_sticky got=%0d exp=1", hit); end
    query(608, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL wall_frozen_head got=%0d exp=%0d", r, C_HEAD); end
    query(592, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL wall_frozen_body got=%0d exp=%0d", r, C_BODY); end
    checks++; if (length !== 5'd3) begin failures++; $display("FAIL wall_length got=%0d exp=3", length); end
    do_reset();
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL wall_rst_hit got=%0d exp=0", hit); end
    query(328, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL wall_rst_head got=%0d exp=%0d", r, C_HEAD); end
    query(608, 245, r);
    checks++; if (r !== C_NONE) begin failures++; $display("FAIL wall_rst_old got=%0d exp=%0d", r, C_NONE); end
  endtask

  task automatic test_self();
    do_reset();
    apple_x = 6'd21; apple_y = 5'd15;
    step(ate);
    apple_x = 6'd22;
    step(ate);
    apple_x = 6'd1; apple_y = 5'd1;
    checks++; if (length !== 5'd5) begin failures++; $display("FAIL self_len5 got=%0d exp=5", length); end
    send_dir(2'b00); step(ate);
    send_dir(2'b10); step(ate);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL self_pre got=%0d exp=0", hit); end
    send_dir(2'b01); step(ate);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL self_hit got=%0d exp=1", hit); end
    query(336, 224, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL self_head_stays got=%0d exp=%0d", r, C_HEAD); end
    // Length 4 loop: head steps into the cell the tail vacates.
    do_reset();
    apple_x = 6'd21; apple_y = 5'd15;
    step(ate);
    apple_x = 6'd1; apple_y = 5'd1;
    send_dir(2'b00); step(ate);
    send_dir(2'b10); step(ate);
    send_dir(2'b01); step(ate);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL tail_chase_hit got=%0d exp=0", hit); end
    query(320, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL tail_chase_head got=%0d exp=%0d", r, C_HEAD); end
    query(336, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL tail_chase_tail got=%0d exp=%0d", r, C_BODY); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 13; k++) begin
      apple_x = 6'(21 + k); apple_y = 5'd15;
      step(ate);
    end
    checks++; if (length !== 5'd16) begin failures++; $display("FAIL sat_len16 got=%0d exp=16", length); end
    apple_x = 6'd34;
    step(ate);
    checks++; if (ate !== 1'b1) begin failures++; $display("FAIL sat_pulse got=%0d exp=1", ate); end
    checks++; if (length !== 5'd16) begin failures++; $display("FAIL sat_len_hold got=%0d exp=16", length); end
    apple_x = 6'd1; apple_y = 5'd1;
    query(544, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL sat_head got=%0d exp=%0d", r, C_HEAD); end
    query(304, 245, r);
    checks++; if (r !== C_BODY) begin failures++; $display("FAIL sat_tail got=%0d exp=%0d", r, C_BODY); end
    query(288, 245, r);
    checks++; if (r !== C_NONE) begin failures++; $display("FAIL sat_dropped got=%0d exp=%0d", r, C_NONE); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    step(ate);
    @(negedge clk);
    rst = 1'b1; move_tick = 1'b1; dir_valid = 1'b1; dir_in = 2'b00;
    @(negedge clk);
    rst = 1'b0; move_tick = 1'b0; dir_valid = 1'b0;
    query(328, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL rst_mid_head got=%0d exp=%0d", r, C_HEAD); end
    step(ate);
    query(336, 245, r);
    checks++; if (r !== C_HEAD) begin failures++; $display("FAIL rst_mid_dir got=%0d exp=%0d", r, C_HEAD); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_reversal();
    test_same_cycle_dir();
    test_eat();
    test_wall();
    test_self();
    test_saturate();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
